parser_head_builder: RTL and testbench
======================================

Name: parser_head_builder

Overview:
- Front stage of the parser pipeline, directly upstream of the first parser layer.
- Accepts a beat-serial packet stream and assembles the first HEAD_WIDTH bits of each packet into a head vector with a per-packet tag appended.
- Seeds the initial lookup/extract offsets from configuration registers and emits one layer_info_t record plus a one-cycle valid strobe per packet.
- Bytes past the head are drained and discarded; the payload path is separate.

Parameters:
- DATA_WIDTH, 256: input beat width in bits; must divide HEAD_WIDTH.
- HEAD_WIDTH, 512: header bits captured (parser_pkg value).
- TAG_WIDTH, 16: per-packet tag width (parser_pkg value).
- HEAD_BEATS, HEAD_WIDTH/DATA_WIDTH: beats needed to fill the head.
- CFG_BASE, 4'hF: value of i_rule_addr[31:28] that selects this block.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous reset, active-high.
- i_data_valid, in, 1: input beat valid.
- i_data, in, DATA_WIDTH: beat data, first byte in MSBs.
- i_data_sop, in, 1: first beat of packet.
- i_data_eop, in, 1: last beat of packet.
- i_data_empty, in, $clog2(DATA_WIDTH/8): invalid trailing bytes on the eop beat.
- o_data_ready, out, 1: beat accepted when valid && ready.
- i_rule_wren, in, 1: config write strobe.
- i_rule_addr, in, 32: config address.
- i_rule_wdata, in, 32: config data.
- o_layer_info, out, layer_info_t: seeded record for layer 0.
- o_layer_valid, out, 1: one-cycle strobe qualifying o_layer_info.
- o_err_cnt, out, 16: saturating count of framing errors.

Behaviour:
- Interface: one clock (i_clk). Reset is synchronous and active-high (i_rst). On reset, every register clears:
  - o_layer_valid=0, o_layer_info all-zero, o_err_cnt=0;
  - tag counter=0, FSM=IDLE, head buffer zero;
  - config registers to 0, including all key_offset_v bits.
- o_data_ready is 0 while i_rst=1 and 1 otherwise. The layer pipeline has no backpressure, so the block never stalls.
- FSM states:
  - IDLE:
    - Accepted beat with sop: store it in head slot 0, beat_cnt=1.
    - If that beat has eop, or HEAD_BEATS==1: go to EMIT. Otherwise go to COLLECT.
    - Accepted beat without sop: discard it, err_cnt+1, stay in IDLE.
  - COLLECT:
    - Accepted beat: store it in slot beat_cnt, beat_cnt+1.
    - If eop: go to EMIT.
    - Else if beat_cnt reaches HEAD_BEATS: go to EMIT_DRAIN.
  - EMIT / EMIT_DRAIN, one cycle each:
    - Assert o_layer_valid and drive o_layer_info.
    - EMIT returns to IDLE; EMIT_DRAIN goes to DRAIN.
    - A beat accepted in the same cycle is processed as if the FSM were already in the next state (IDLE or DRAIN respectively).
  - DRAIN: discard beats; on eop go to IDLE.
- Head assembly:
  - Slot k occupies head bits [HEAD_WIDTH+TAG_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH].
  - On the eop beat, the last i_data_empty bytes are zeroed.
  - Unfilled slots of a short packet are zero.
  - The low TAG_WIDTH bits carry the tag.
- Emitted record fields:
  - head = {assembled bits, tag};
  - meta = {zeros, tag};
  - type_offset, key_offset, key_offset_v, headShift, metaShift come from the config registers, sampled in the EMIT cycle.
- Latency: o_layer_valid rises the cycle after the beat that completes the head (the eop beat or beat HEAD_BEATS).
- Tag: increments by 1 after each emission and wraps modulo 2^TAG_WIDTH.
- Framing errors:
  - sop in COLLECT: the partial head is dropped without emission, err_cnt+1, and the beat starts a new packet.
  - sop in DRAIN: the new packet starts normally, err_cnt+1.
  - sop+eop in the same beat is a valid 1-beat packet.
  - err_cnt saturates at 16'hFFFF.
- Config writes take effect when i_rule_wren=1 and i_rule_addr[31:28]==CFG_BASE. The write lands in the register the next cycle. addr[7:4] selects the class and addr[3:0] the index:
  - 0: type_offset[idx];
  - 1: key_offset[idx];
  - 2: key_offset_v[idx] = wdata[0];
  - 3: headShift;
  - 4: metaShift.
- Config write edge cases:
  - Out-of-range indices and other classes are ignored.
  - A write in the same cycle as EMIT is not visible to that emission.

Test Plan:
- 4-beat packet, beats 0xA…, 0xB…, 0xC…, 0xD… (HEAD_BEATS=2) -> one valid strobe one cycle after beat 1; head = {A-beat, B-beat, tag 0}; beats 2–3 are drained; no second strobe.
- Single beat with sop=eop and i_data_empty=4 -> strobe next cycle; last 4 bytes of slot 0 and all of slot 1 are zero.
- Three back-to-back 1-beat packets -> three strobes on consecutive cycles with tags 0, 1, 2. Preload tag to 0xFFFF via 0xFFFF packets -> next tag wraps to 0.
- sop, then sop again before eop -> only the second packet is emitted; err_cnt=1. A beat without sop while IDLE -> err_cnt=2, no strobe.
- Write type_offset[0]=5, key_offset_v[1]=1, headShift=3, then send a packet -> o_layer_info carries 5, key_offset_v=…10, 3. A write to CFG_BASE≠0xF changes nothing.
- Assert i_rst for 1 cycle in COLLECT -> no strobe for the partial packet; tag, err_cnt and config read back 0; the next packet emits with tag 0.

Source files
------------

// File: rtl/parser_head_builder_if.sv
`default_nettype none
// ============================================================================
//  Module   : parser_head_builder_pkg / parser_head_builder_if
//  Purpose  : Shared layer record type and the beat-serial packet stream
//             bundle feeding the parser head builder.
//  Revision : 1.0  initial release
// ============================================================================

package parser_head_builder_pkg;
   localparam int PKG_HEAD_WIDTH = 512;
   localparam int PKG_TAG_WIDTH  = 16;
   localparam int META_WIDTH     = 64;
   localparam int NUM_OFFSETS    = 2;
   localparam int OFFSET_WIDTH   = 8;

   typedef struct packed {
      logic [PKG_HEAD_WIDTH+PKG_TAG_WIDTH-1:0]      head;
      logic [META_WIDTH-1:0]                        meta;
      logic [NUM_OFFSETS-1:0][OFFSET_WIDTH-1:0]     type_offset;
      logic [NUM_OFFSETS-1:0][OFFSET_WIDTH-1:0]     key_offset;
      logic [NUM_OFFSETS-1:0]                       key_offset_v;
      logic [OFFSET_WIDTH-1:0]                      headShift;
      logic [OFFSET_WIDTH-1:0]                      metaShift;
   } layer_info_t;
endpackage

interface parser_head_builder_if #(
   parameter int DATA_WIDTH = 256
);
   localparam int EW = $clog2(DATA_WIDTH/8);

   logic                  data_valid;
   logic [DATA_WIDTH-1:0] data;
   logic                  data_sop;
   logic                  data_eop;
   logic [EW-1:0]         data_empty;
   logic                  data_ready;

   modport master (
      output data_valid, data, data_sop, data_eop, data_empty,
      input  data_ready
   );

   modport slave (
      input  data_valid, data, data_sop, data_eop, data_empty,
      output data_ready
   );
endinterface

`default_nettype wire

// File: rtl/parser_head_builder.sv
`default_nettype none
// ============================================================================
//  Module   : parser_head_builder
//  Purpose  : Collects the first HEAD_WIDTH bits of each packet, appends a
//             per-packet tag, seeds offsets from config registers and emits
//             one layer record with a single-cycle strobe per packet.
//  Revision : 1.0  initial release
// ============================================================================

module parser_head_builder
   import parser_head_builder_pkg::*;
#(
   parameter int         DATA_WIDTH = 256,
   parameter int         HEAD_WIDTH = PKG_HEAD_WIDTH,
   parameter int         TAG_WIDTH  = PKG_TAG_WIDTH,
   parameter int         HEAD_BEATS = HEAD_WIDTH / DATA_WIDTH,
   parameter logic [3:0] CFG_BASE   = 4'hF
) (
   input  wire logic               i_clk,
   input  wire logic               i_rst,
   parser_head_builder_if.slave    io_data,
   input  wire logic               i_rule_wren,
   input  wire logic [31:0]        i_rule_addr,
   input  wire logic [31:0]        i_rule_wdata,
   output layer_info_t             o_layer_info,
   output logic                    o_layer_valid,
   output logic [15:0]             o_err_cnt
);

   localparam int CW = $clog2(HEAD_BEATS + 1);

   localparam logic [2:0] c_IDLE       = 3'd0;
   localparam logic [2:0] c_COLLECT    = 3'd1;
   localparam logic [2:0] c_EMIT       = 3'd2;
   localparam logic [2:0] c_EMIT_DRAIN = 3'd3;
   localparam logic [2:0] c_DRAIN      = 3'd4;

   logic [2:0]                                 r_state;
   logic [2:0]                                 w_next;
   logic [2:0]                                 w_base;
   logic [HEAD_WIDTH-1:0]                      r_head;
   logic [CW-1:0]                              r_beat_cnt;
   logic [TAG_WIDTH-1:0]                       r_tag;
   logic [15:0]                                r_err_cnt;
   logic [NUM_OFFSETS-1:0][OFFSET_WIDTH-1:0]   r_type_off;
   logic [NUM_OFFSETS-1:0][OFFSET_WIDTH-1:0]   r_key_off;
   logic [NUM_OFFSETS-1:0]                     r_key_v;
   logic [OFFSET_WIDTH-1:0]                    r_head_shift;
   logic [OFFSET_WIDTH-1:0]                    r_meta_shift;

   logic                  w_acc;
   logic                  w_sop;
   logic                  w_eop;
   logic                  w_start;
   logic                  w_store;
   logic                  w_err;
   logic                  w_first_done;
   logic                  w_last_slot;
   logic                  w_cfg_hit;
   logic [DATA_WIDTH-1:0] w_keep_mask;
   logic [DATA_WIDTH-1:0] w_beat;
   logic [3:0]            w_cfg_idx;
   logic                  w_unused;

   // The layer pipeline never pushes back, so the stream is only held off in reset.
   assign io_data.data_ready = ~i_rst;

   assign w_acc = io_data.data_valid & io_data.data_ready;
   assign w_sop = io_data.data_sop;
   assign w_eop = io_data.data_eop;

   // Trailing invalid bytes sit in the LSBs of the eop beat.
   assign w_keep_mask = {DATA_WIDTH{1'b1}} << {io_data.data_empty, 3'b000};
   assign w_beat      = w_eop ? (io_data.data & w_keep_mask) : io_data.data;

   // The emit states handle a concurrent beat as if already in their successor.
   assign w_base = (r_state == c_EMIT)       ? c_IDLE  :
                   (r_state == c_EMIT_DRAIN) ? c_DRAIN : r_state;

   // A sop beat always (re)starts a packet; sop outside IDLE is a framing error.
   assign w_start      = w_acc & w_sop;
   assign w_store      = w_acc & ~w_sop & (w_base == c_COLLECT);
   assign w_err        = w_acc & ((w_base == c_IDLE) ? ~w_sop : w_sop);
   assign w_first_done = w_eop | (HEAD_BEATS == 1);
   assign w_last_slot  = (r_beat_cnt == CW'(HEAD_BEATS - 1));

   assign w_cfg_hit = i_rule_wren & (i_rule_addr[31:28] == CFG_BASE);
   assign w_cfg_idx = i_rule_addr[3:0];
   assign w_unused  = &{1'b0, i_rule_addr[27:8], i_rule_wdata[31:8]};

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= c_IDLE;
      else       r_state <= w_next;
   end

   // FSM next-state decode.
   always_comb begin
      w_next = w_base;
      if (w_acc) begin
         if (w_sop) begin
            w_next = w_first_done ? c_EMIT : c_COLLECT;
         end else begin
            case (w_base)
               c_COLLECT: begin
                  if (w_eop)            w_next = c_EMIT;
                  else if (w_last_slot) w_next = c_EMIT_DRAIN;
               end
               c_DRAIN: if (w_eop) w_next = c_IDLE;
               default: w_next = w_base;
            endcase
         end
      end
   end

   // FSM outputs: the record is presented only while the strobe is high.
   always_comb begin
      o_layer_valid = (r_state == c_EMIT) || (r_state == c_EMIT_DRAIN);
      o_layer_info  = '0;
      if (o_layer_valid) begin
         o_layer_info.head         = {r_head, r_tag};
         o_layer_info.meta         = META_WIDTH'(r_tag);
         o_layer_info.type_offset  = r_type_off;
         o_layer_info.key_offset   = r_key_off;
         o_layer_info.key_offset_v = r_key_v;
         o_layer_info.headShift    = r_head_shift;
         o_layer_info.metaShift    = r_meta_shift;
      end
   end

   // Head assembly, tag sequencing and framing-error counting.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head     <= '0;
         r_beat_cnt <= '0;
         r_tag      <= '0;
         r_err_cnt  <= '0;
      end else begin
         if (w_start) begin
            // Clearing first leaves unfilled slots of a short packet at zero.
            r_head <= '0;
            r_head[HEAD_WIDTH-1 -: DATA_WIDTH] <= w_beat;
            r_beat_cnt <= CW'(1);
         end else if (w_store) begin
            for (int k = 0; k < HEAD_BEATS; k++) begin
               if (r_beat_cnt == CW'(k))
                  r_head[HEAD_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH] <= w_beat;
            end
            r_beat_cnt <= r_beat_cnt + CW'(1);
         end
         if (o_layer_valid)
            r_tag <= r_tag + TAG_WIDTH'(1);
         if (w_err && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   // Configuration register writes; unknown classes and indices are dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_type_off   <= '0;
         r_key_off    <= '0;
         r_key_v      <= '0;
         r_head_shift <= '0;
         r_meta_shift <= '0;
      end else if (w_cfg_hit) begin
         case (i_rule_addr[7:4])
            4'd0: for (int n = 0; n < NUM_OFFSETS; n++)
                     if (w_cfg_idx == 4'(n)) r_type_off[n] <= i_rule_wdata[7:0];
            4'd1: for (int n = 0; n < NUM_OFFSETS; n++)
                     if (w_cfg_idx == 4'(n)) r_key_off[n] <= i_rule_wdata[7:0];
            4'd2: for (int n = 0; n < NUM_OFFSETS; n++)
                     if (w_cfg_idx == 4'(n)) r_key_v[n] <= i_rule_wdata[0];
            4'd3: r_head_shift <= i_rule_wdata[7:0];
            4'd4: r_meta_shift <= i_rule_wdata[7:0];
            default: ;
         endcase
      end
   end

   assign o_err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_parser_head_builder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parser_head_builder
//  Purpose  : Directed self-checking bench for parser_head_builder.
//  Revision : 1.0  initial release
// ============================================================================

module tb_parser_head_builder;
   import parser_head_builder_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        rule_wren;
   logic [31:0] rule_addr;
   logic [31:0] rule_wdata;
   layer_info_t layer_info;
   logic        layer_valid;
   logic [15:0] err_cnt;

   int n_checks = 0;
   int n_err    = 0;

   parser_head_builder_if #(.DATA_WIDTH(256)) bus ();

   parser_head_builder dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .io_data      (bus),
      .i_rule_wren  (rule_wren),
      .i_rule_addr  (rule_addr),
      .i_rule_wdata (rule_wdata),
      .o_layer_info (layer_info),
      .o_layer_valid(layer_valid),
      .o_err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [255:0] d, input logic sop, input logic eop,
                            input logic [4:0] empty);
      bus.data_valid = 1'b1;
      bus.data       = d;
      bus.data_sop   = sop;
      bus.data_eop   = eop;
      bus.data_empty = empty;
      @(posedge clk); #1;
      bus.data_valid = 1'b0;
      bus.data_sop   = 1'b0;
      bus.data_eop   = 1'b0;
      bus.data_empty = '0;
   endtask

   task automatic idle(input int n);
      bus.data_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
      rule_wren  = 1'b1;
      rule_addr  = a;
      rule_wdata = d;
      @(posedge clk); #1;
      rule_wren  = 1'b0;
   endtask

   logic [255:0] BA, BB, BC, BD, BE, EM, F1, F2, F3, BG, BH, BI, BJ, BK, BL, BM, BQ;

   initial begin
      BA = {32{8'hA1}}; BB = {32{8'hB2}}; BC = {32{8'hC3}}; BD = {32{8'hD4}};
      BE = {32{8'hE5}}; EM = {{28{8'hE5}}, 32'h0};
      F1 = {32{8'h11}}; F2 = {32{8'h22}}; F3 = {32{8'h33}};
      BG = {32{8'h47}}; BH = {32{8'h48}}; BI = {32{8'h49}}; BJ = {32{8'h4A}};
      BK = {32{8'h5B}}; BL = {32{8'h5C}}; BM = {32{8'h5D}}; BQ = {32{8'h6E}};

      rst = 1'b1; rule_wren = 1'b0; rule_addr = '0; rule_wdata = '0;
      bus.data_valid = 1'b0; bus.data = '0; bus.data_sop = 1'b0;
      bus.data_eop = 1'b0; bus.data_empty = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", bus.data_ready, 1'b0);
      chk("rst_valid", layer_valid, 1'b0);
      chk("rst_info", layer_info, '0);
      chk("rst_err", err_cnt, 16'd0);
      rst = 1'b0;
      #1;
      chk("ready", bus.data_ready, 1'b1);

      // 4-beat packet: head built from the first two beats, rest drained
      send_beat(BA, 1'b1, 1'b0, 5'd0);
      chk("p4_b0_valid", layer_valid, 1'b0);
      send_beat(BB, 1'b0, 1'b0, 5'd0);
      chk("p4_valid", layer_valid, 1'b1);
      chk("p4_head", layer_info.head, {BA, BB, 16'd0});
      chk("p4_meta", layer_info.meta, 64'd0);
      send_beat(BC, 1'b0, 1'b0, 5'd0);
      chk("p4_drain1", layer_valid, 1'b0);
      send_beat(BD, 1'b0, 1'b1, 5'd0);
      chk("p4_drain2", layer_valid, 1'b0);
      idle(2);
      chk("p4_no_second", layer_valid, 1'b0);
      chk("p4_err", err_cnt, 16'd0);

      // Single beat with 4 empty bytes
      send_beat(BE, 1'b1, 1'b1, 5'd4);
      chk("short_valid", layer_valid, 1'b1);
      chk("short_head", layer_info.head, {EM, 256'd0, 16'd1});
      idle(1);

      // Back-to-back single-beat packets
      send_beat(F1, 1'b1, 1'b1, 5'd0);
      chk("b2b0_tag", layer_info.meta, 64'd2);
      send_beat(F2, 1'b1, 1'b1, 5'd0);
      chk("b2b1_valid", layer_valid, 1'b1);
      chk("b2b1_head", layer_info.head, {F2, 256'd0, 16'd3});
      send_beat(F3, 1'b1, 1'b1, 5'd0);
      chk("b2b2_tag", layer_info.meta, 64'd4);
      idle(1);
      chk("b2b_end", layer_valid, 1'b0);

      // Advance the tag to 0xFFFF, then check wrap
      for (int i = 0; i < 65530; i++) send_beat(F1, 1'b1, 1'b1, 5'd0);
      send_beat(F1, 1'b1, 1'b1, 5'd0);
      chk("tag_ffff", layer_info.meta, 64'hFFFF);
      send_beat(F1, 1'b1, 1'b1, 5'd0);
      chk("tag_wrap", layer_info.meta, 64'h0);

      // sop in COLLECT: first partial head dropped
      send_beat(BG, 1'b1, 1'b0, 5'd0);
      chk("fr_g_valid", layer_valid, 1'b0);
      send_beat(BH, 1'b1, 1'b0, 5'd0);
      chk("fr_h_valid", layer_valid, 1'b0);
      send_beat(BI, 1'b0, 1'b1, 5'd0);
      chk("fr_valid", layer_valid, 1'b1);
      chk("fr_head", layer_info.head, {BH, BI, 16'd1});
      chk("fr_err1", err_cnt, 16'd1);
      idle(1);
      // Beat without sop while IDLE
      send_beat(BJ, 1'b0, 1'b1, 5'd0);
      chk("nosop_valid", layer_valid, 1'b0);
      chk("nosop_err2", err_cnt, 16'd2);

      // sop while draining starts a new packet
      send_beat(BK, 1'b1, 1'b0, 5'd0);
      send_beat(BL, 1'b0, 1'b0, 5'd0);
      chk("dr_head", layer_info.head, {BK, BL, 16'd2});
      send_beat(BM, 1'b1, 1'b1, 5'd0);
      chk("dr_valid", layer_valid, 1'b1);
      chk("dr_head2", layer_info.head, {BM, 256'd0, 16'd3});
      chk("dr_err3", err_cnt, 16'd3);
      idle(1);

      // Configuration writes, including ignored ones
      cfg_write(32'hF000_0000, 32'd5);
      cfg_write(32'hF000_0021, 32'd1);
      cfg_write(32'hF000_0030, 32'd3);
      cfg_write(32'hE000_0040, 32'd9);
      cfg_write(32'hF000_0005, 32'd7);
      cfg_write(32'hF000_0050, 32'd8);
      send_beat(BQ, 1'b1, 1'b1, 5'd0);
      chk("cfg_type", layer_info.type_offset, 16'h0005);
      chk("cfg_key", layer_info.key_offset, 16'h0000);
      chk("cfg_keyv", layer_info.key_offset_v, 2'b10);
      chk("cfg_hshift", layer_info.headShift, 8'd3);
      chk("cfg_mshift", layer_info.metaShift, 8'd0);
      // Write coinciding with an emission is not seen by it
      rule_wren = 1'b1; rule_addr = 32'hF000_0040; rule_wdata = 32'h77;
      #1;
      chk("cfg_same_cycle", layer_info.metaShift, 8'd0);
      @(posedge clk); #1;
      rule_wren = 1'b0;
      send_beat(BQ, 1'b1, 1'b1, 5'd0);
      chk("cfg_after", layer_info.metaShift, 8'h77);
      chk("cfg_tag", layer_info.meta, 64'd5);
      idle(1);

      // Reset in the middle of a packet
      send_beat(BG, 1'b1, 1'b0, 5'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mrst_valid", layer_valid, 1'b0);
      chk("mrst_err", err_cnt, 16'd0);
      idle(2);
      chk("mrst_nostrobe", layer_valid, 1'b0);
      send_beat(BQ, 1'b1, 1'b1, 5'd0);
      chk("mrst_pkt_valid", layer_valid, 1'b1);
      chk("mrst_head", layer_info.head, {BQ, 256'd0, 16'd0});
      chk("mrst_type", layer_info.type_offset, 16'h0000);
      chk("mrst_keyv", layer_info.key_offset_v, 2'b00);
      chk("mrst_hshift", layer_info.headShift, 8'd0);
      chk("mrst_mshift", layer_info.metaShift, 8'd0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
